alu_op_driver: RTL and testbench
================================

Name: alu_op_driver

Overview:
Initiator-side front end for the registered 8-bit ALU (ops: 0000 add, 0001 sub, 0010 mul, 0011 div). It accepts self-checking commands over a valid/ready port and drives A/B/ALU_Sel into the ALU. After the ALU latency it samples ALU_Out/CarryOut and compares them with the expected values. It returns a response record and keeps pass/fail counters. It replaces hand-sequenced `#10` stimulus with a synthesizable, cycle-exact driver usable in benches and on-chip BIST.

Parameters:
ALU_LAT, 1, rising edges from operands applied to ALU result stable; legal range 1..15
CNT_W, 16, width of pass/fail counters

Ports:
clock  input  1  single clock, rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  driver can accept a command
cmd_a  input  8  operand A
cmd_b  input  8  operand B
cmd_sel  input  4  ALU_Sel code
cmd_exp_out  input  8  expected ALU_Out
cmd_exp_carry  input  1  expected CarryOut
cmd_chk_carry  input  1  1 = compare CarryOut, 0 = ignore it (e.g. div)
alu_a  output  8  to ALU A
alu_b  output  8  to ALU B
alu_sel  output  4  to ALU ALU_Sel
alu_out  input  8  from ALU ALU_Out
alu_carry  input  1  from ALU CarryOut
rsp_valid  output  1  response available
rsp_ready  input  1  response consumer ready
rsp_out  output  8  sampled ALU_Out
rsp_carry  output  1  sampled CarryOut
rsp_pass  output  1  1 = matched expectation
pass_cnt  output  CNT_W  passing commands
fail_cnt  output  CNT_W  failing commands
busy  output  1  state != IDLE

Behaviour:
- Reset value of every register and output is 0, except cmd_ready. cmd_ready is 1 once reset deasserts, unless halted (see Optional Feature).
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid && cmd_ready at edge T0: register cmd_a/b/sel onto alu_a/b/sel and latch the expectation fields.
  - Load the wait counter with ALU_LAT and go to WAIT.
- WAIT:
  - cmd_ready = 0.
  - The counter decrements each edge.
  - When the counter is 0, the next edge (T0+ALU_LAT+1) does the following:
    - registers rsp_out=alu_out and rsp_carry=alu_carry;
    - sets rsp_pass = (alu_out==exp_out) && (!chk_carry || alu_carry==exp_carry);
    - increments pass_cnt or fail_cnt;
    - enters RESP.
- Latency: the accept edge to rsp_valid high is exactly ALU_LAT+1 cycles.
- RESP:
  - rsp_valid = 1; rsp_* held stable until rsp_ready.
  - On rsp_valid && rsp_ready, go to IDLE.
  - cmd_ready rises the cycle after the handshake. There is no combinational ready-to-ready path.
- Throughput: at best one command per ALU_LAT+3 cycles (rsp_ready tied high).
- alu_a/b/sel hold the last driven values in IDLE and RESP. They are never returned to 0 except by reset.
- Counters saturate at 2^CNT_W-1 and do not wrap.
- Inputs are ignored outside IDLE:
  - cmd_valid asserted while busy is ignored; the command is not lost because ready=0.
  - rsp_ready asserted outside RESP has no effect.
- Async reset mid-WAIT or mid-RESP:
  - the in-flight command is dropped with no counter update;
  - all outputs go to reset values immediately;
  - operation resumes in IDLE on the first edge after reset deasserts.
- The ALU's own reset polarity is handled by the integrating level and is out of scope here.

Optional Feature:
Macro ALU_DRV_STOP_ON_FAIL_EN.
- Defined:
  - A failing compare sets a sticky halted register on the same edge that increments fail_cnt.
  - The failing response is still delivered normally.
  - After that handshake the FSM returns to IDLE, but cmd_ready stays 0 until reset.
  - busy stays 1 while halted.
- Undefined: no halted register; failures only increment fail_cnt and the driver keeps accepting commands.

Test Plan:
- Reset pulse low for 2 cycles, then release -> all outputs 0, cmd_ready=1, busy=0.
- Add A=9D, B=60, sel 0000, exp FD, carry 0, chk=1; ALU_LAT=1; rsp_ready=1 -> rsp_valid exactly 2 cycles after accept, rsp_out=FD, rsp_pass=1, pass_cnt=1. Then A=B1, B=9F, exp 50, carry 1 -> pass_cnt=2.
- Sub A=EA, B=3C, exp AE, carry 1, chk=1, but the ALU model returns carry 0 -> rsp_pass=0, fail_cnt=1. With ALU_DRV_STOP_ON_FAIL_EN: cmd_ready stays 0 after the response handshake until reset.
- Div A=F4, B=2F, exp 05, chk=0, ALU model carry arbitrary; rsp_ready held 0 for 5 cycles -> rsp_* stable throughout, cmd_ready=0, single counter increment. Then ready=1 -> IDLE next cycle.
- Back-to-back cmd_valid held high for 4 commands (mul 0E*0B exp 9A, 0C*03 exp 24, 0F*0A exp 96, 00*00 exp 00) -> each accepted only in IDLE, pass_cnt=4, no command skipped or duplicated.
- Reset asserted in WAIT cycle of a command -> no counter change, rsp_valid=0, alu_a/b/sel=0 immediately. Next command after release completes normally.

Source files
------------

// File: rtl/alu_op_driver.sv
// Self-checking command driver for a registered 8-bit ALU: issues operands, samples the result
// after ALU_LAT edges, compares it with the expectation and counts passes/fails.
// Optional halt-after-first-failure behaviour is enabled by defining ALU_DRV_STOP_ON_FAIL_EN.
module alu_op_driver #(
  parameter int unsigned ALU_LAT = 1,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [7:0]       cmd_a,
  input  logic [7:0]       cmd_b,
  input  logic [3:0]       cmd_sel,
  input  logic [7:0]       cmd_exp_out,
  input  logic             cmd_exp_carry,
  input  logic             cmd_chk_carry,
  output logic [7:0]       alu_a,
  output logic [7:0]       alu_b,
  output logic [3:0]       alu_sel,
  input  logic [7:0]       alu_out,
  input  logic             alu_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_out,
  output logic             rsp_carry,
  output logic             rsp_pass,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [3:0]       LAT_LOAD = 4'(ALU_LAT);

  state_t     state;
  logic [3:0] wait_cnt;
  logic [7:0] exp_out;
  logic       exp_carry;
  logic       chk_carry;
  logic       halted;
  logic       match;

  assign match     = (alu_out == exp_out) && (!chk_carry || (alu_carry == exp_carry));
  assign cmd_ready = (state == IDLE) && !halted;
  assign busy      = (state != IDLE) || halted;

`ifdef ALU_DRV_STOP_ON_FAIL_EN
  // Sticky: set on the failing sample, cleared only by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)
      halted <= 1'b0;
    else if (state == WAIT && wait_cnt == '0 && !match)
      halted <= 1'b1;
  end
`else
  assign halted = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      exp_out   <= '0;
      exp_carry <= 1'b0;
      chk_carry <= 1'b0;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_sel   <= '0;
      rsp_valid <= 1'b0;
      rsp_out   <= '0;
      rsp_carry <= 1'b0;
      rsp_pass  <= 1'b0;
      pass_cnt  <= '0;
      fail_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            alu_a     <= cmd_a;
            alu_b     <= cmd_b;
            alu_sel   <= cmd_sel;
            exp_out   <= cmd_exp_out;
            exp_carry <= cmd_exp_carry;
            chk_carry <= cmd_chk_carry;
            wait_cnt  <= LAT_LOAD;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_out   <= alu_out;
            rsp_carry <= alu_carry;
            rsp_pass  <= match;
            rsp_valid <= 1'b1;
            if (match) begin
              if (pass_cnt != CNT_MAX) pass_cnt <= pass_cnt + 1'b1;
            end else begin
              if (fail_cnt != CNT_MAX) fail_cnt <= fail_cnt + 1'b1;
            end
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_driver.sv
// Randomized and directed bench for alu_op_driver with a behavioural ALU and reference model.
// Honours ALU_DRV_STOP_ON_FAIL_EN when the design is built with it.
module tb_alu_op_driver;

  localparam int unsigned LAT = 1;
  localparam int unsigned CW  = 3;
  localparam int unsigned CNT_SAT = (1 << CW) - 1;

  logic          clock, reset;
  logic          cmd_valid, cmd_ready;
  logic [7:0]    cmd_a, cmd_b, cmd_exp_out;
  logic [3:0]    cmd_sel;
  logic          cmd_exp_carry, cmd_chk_carry;
  logic [7:0]    alu_a, alu_b, alu_out;
  logic [3:0]    alu_sel;
  logic          alu_carry;
  logic          rsp_valid, rsp_ready, rsp_carry, rsp_pass;
  logic [7:0]    rsp_out;
  logic [CW-1:0] pass_cnt, fail_cnt;
  logic          busy;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned pass_m   = 0;
  int unsigned fail_m   = 0;
  bit          halted_m = 0;
  bit          inject   = 0;

  alu_op_driver #(.ALU_LAT(LAT), .CNT_W(CW)) dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_sel(cmd_sel),
    .cmd_exp_out(cmd_exp_out), .cmd_exp_carry(cmd_exp_carry), .cmd_chk_carry(cmd_chk_carry),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_out(alu_out), .alu_carry(alu_carry),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_out(rsp_out), .rsp_carry(rsp_carry), .rsp_pass(rsp_pass),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .busy(busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural ALU: {carry, out}; div carry is deliberately arbitrary (a[0]).
  function automatic logic [8:0] alu_ref(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    logic [8:0]  s;
    logic [15:0] p;
    case (sel)
      4'd0: begin s = {1'b0, a} + {1'b0, b}; return s; end
      4'd1: return {(a >= b), 8'(a - b)};
      4'd2: begin p = a * b; return {(p[15:8] != 8'd0), p[7:0]}; end
      4'd3: return (b == 8'd0) ? {a[0], 8'hFF} : {a[0], 8'(a / b)};
      default: return 9'd0;
    endcase
  endfunction

  logic [8:0] pipe [LAT];
  always @(posedge clock) begin
    pipe[0] <= alu_ref(alu_a, alu_b, alu_sel);
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign alu_out   = pipe[LAT-1][7:0];
  assign alu_carry = inject ? 1'b0 : pipe[LAT-1][8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    pass_m = 0; fail_m = 0; halted_m = 0;
  endtask

  // Issue one command and retire it; starts and ends at a negedge.
  task automatic run_cmd(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                         input logic [7:0] e, input logic ec, input logic chk,
                         input int unsigned stall, input bit hold_valid, input bit inj);
    logic [8:0]  r;
    logic        c, pass;
    int unsigned k;
    logic [17:0] snap;
    if (halted_m) do_reset();
    inject = inj;
    cmd_a = a; cmd_b = b; cmd_sel = sel; cmd_exp_out = e; cmd_exp_carry = ec; cmd_chk_carry = chk;
    cmd_valid = 1'b1;
    k = 0;
    while (!cmd_ready && k < 50) begin @(negedge clock); k++; end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0; inject = 0;
      return;
    end
    @(posedge clock);
    @(negedge clock);
    if (!hold_valid) cmd_valid = 1'b0;
    check("ready_in_wait", 32'({cmd_ready, busy}), 32'b01);
    k = 0;
    while (!rsp_valid && k < 40) begin @(negedge clock); k++; end
    check("latency", k, LAT + 1);

    r = alu_ref(a, b, sel);
    c = inj ? 1'b0 : r[8];
    pass = (r[7:0] == e) && (!chk || c == ec);
    if (pass) begin if (pass_m < CNT_SAT) pass_m++; end
    else begin
      if (fail_m < CNT_SAT) fail_m++;
`ifdef ALU_DRV_STOP_ON_FAIL_EN
      halted_m = 1;
`endif
    end
    check("rsp_out", 32'(rsp_out), 32'(r[7:0]));
    check("rsp_carry", 32'(rsp_carry), 32'(c));
    check("rsp_pass", 32'(rsp_pass), 32'(pass));
    check("pass_cnt", 32'(pass_cnt), pass_m);
    check("fail_cnt", 32'(fail_cnt), fail_m);

    snap = {1'b1, 1'b0, r[7:0], c, pass, CW'(pass_m), CW'(fail_m)};
    for (int i = 0; i < int'(stall); i++) begin
      @(negedge clock);
      check("rsp_hold", 32'({rsp_valid, cmd_ready, rsp_out, rsp_carry, rsp_pass, pass_cnt, fail_cnt}), 32'(snap));
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    rsp_ready = 1'b0;
    inject = 0;
    check("after_hs", 32'({rsp_valid, cmd_ready}), 32'({1'b0, !halted_m}));
  endtask

  initial begin
    logic [7:0] ra, rb, re;
    logic [3:0] rs;
    logic [8:0] rr;
    logic       rec, rchk;
    reset = 1'b0; cmd_valid = 1'b0; rsp_ready = 1'b0;
    cmd_a = '0; cmd_b = '0; cmd_sel = '0; cmd_exp_out = '0; cmd_exp_carry = 1'b0; cmd_chk_carry = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    check("reset_ready_busy", 32'({cmd_ready, busy, rsp_valid}), 32'b100);
    check("reset_alu", 32'({alu_a, alu_b, alu_sel}), 32'd0);
    check("reset_rsp", 32'({rsp_out, rsp_carry, rsp_pass, pass_cnt, fail_cnt}), 32'd0);

    run_cmd(8'h9D, 8'h60, 4'd0, 8'hFD, 1'b0, 1'b1, 0, 0, 0);
    run_cmd(8'hB1, 8'h9F, 4'd0, 8'h50, 1'b1, 1'b1, 0, 0, 0);
    run_cmd(8'hEA, 8'h3C, 4'd1, 8'hAE, 1'b1, 1'b1, 1, 0, 1);
    run_cmd(8'hF4, 8'h2F, 4'd3, 8'h05, 1'b0, 1'b0, 5, 0, 0);

    run_cmd(8'h0E, 8'h0B, 4'd2, 8'h9A, 1'b0, 1'b1, 0, 1, 0);
    run_cmd(8'h0C, 8'h03, 4'd2, 8'h24, 1'b0, 1'b1, 0, 1, 0);
    run_cmd(8'h0F, 8'h0A, 4'd2, 8'h96, 1'b0, 1'b1, 0, 1, 0);
    run_cmd(8'h00, 8'h00, 4'd2, 8'h00, 1'b0, 1'b1, 0, 0, 0);

    // Reset while the command sits in WAIT.
    if (halted_m) do_reset();
    cmd_a = 8'h12; cmd_b = 8'h34; cmd_sel = 4'd0; cmd_exp_out = 8'h46; cmd_valid = 1'b1;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    check("midwait_busy", 32'(busy), 32'd1);
    #1 reset = 1'b0;
    #1;
    check("midwait_reset_out", 32'({rsp_valid, busy, alu_a, alu_b, alu_sel}), 32'd0);
    check("midwait_reset_cnt", 32'({pass_cnt, fail_cnt}), 32'd0);
    @(negedge clock);
    reset = 1'b1;
    pass_m = 0; fail_m = 0; halted_m = 0;
    @(negedge clock);
    run_cmd(8'h21, 8'h05, 4'd1, 8'h1C, 1'b1, 1'b1, 0, 0, 0);

    for (int n = 0; n < 30; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rs = 4'($urandom_range(0, 3));
      rr = alu_ref(ra, rb, rs);
      re = ($urandom_range(0, 3) != 0) ? rr[7:0] : 8'($urandom);
      rec = ($urandom_range(0, 3) != 0) ? rr[8] : 1'($urandom);
      rchk = 1'($urandom);
      run_cmd(ra, rb, rs, re, rec, rchk, $urandom_range(0, 3), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
